// File: rtl/vu_level_ctrl_pkg.sv
// Shared definitions for the VU meter level path: FSM encodings and the
// default sample/level widths that the bar renderer also relies on.
package vu_level_ctrl_pkg;

    // Defaults shared with the renderer so both ends agree on bar resolution.
    localparam int SAMPLE_W_DEF    = 8;
    localparam int LEVEL_W_DEF     = 5;
    localparam int DECAY_STEP_DEF  = 1;
    localparam int HOLD_FRAMES_DEF = 30;

    // Commit sequencer state type and encodings.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_UPD_LEVEL = 2'd1;
    localparam state_t ST_UPD_PEAK  = 2'd2;

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold marker for the VU bar. On each commit it either jumps up to the
// freshly committed level, freezes for a number of frames, or falls off
// towards the level one decay step per frame.
module vu_peak_hold
    import vu_level_ctrl_pkg::*;
#(
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int DECAY_STEP  = DECAY_STEP_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic               clk_board,
    input  logic               reset,
    input  logic               update,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] peak
);

    localparam int                 HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [LEVEL_W-1:0] DECAY     = LEVEL_W'(DECAY_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_next;
    logic [LEVEL_W-1:0] peak_next;
    logic [LEVEL_W-1:0] peak_decayed;

    // Next peak/hold: new peak restarts the hold, otherwise count the hold
    // down before letting the marker fall (never below the level, never wrapping).
    always_comb begin
        peak_decayed = (peak > DECAY) ? (peak - DECAY) : '0;
        peak_next    = peak;
        hold_next    = hold;
        if (level >= peak) begin
            peak_next = level;
            hold_next = HOLD_INIT;
        end else if (hold != '0) begin
            hold_next = hold - 1'b1;
        end else if (level > peak_decayed) begin
            peak_next = level;
        end else begin
            peak_next = peak_decayed;
        end
    end

    // Peak register and hold counter only move on the commit cycle.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            peak <= '0;
            hold <= '0;
        end else if (update) begin
            peak <= peak_next;
            hold <= hold_next;
        end
    end

endmodule

// File: rtl/vu_level_ctrl.sv
// Frame-synchronous level scheduler between the UART receiver and the VGA
// bar renderer. Bytes arriving during a frame are reduced to their maximum;
// at frame start the maximum is committed as a new bar level (with fall-off)
// and a peak marker, so the renderer only ever sees whole-frame updates.
module vu_level_ctrl
    import vu_level_ctrl_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int DECAY_STEP  = DECAY_STEP_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic                clk_board,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] rx_data,
    input  logic                rx_valid,
    input  logic                frame_start,
    output logic [LEVEL_W-1:0]  level,
    output logic [LEVEL_W-1:0]  peak,
    output logic                level_valid
);

    localparam int                 SHIFT = SAMPLE_W - LEVEL_W;
    localparam logic [LEVEL_W-1:0] DECAY = LEVEL_W'(DECAY_STEP);

    state_t              state;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W-1:0] cand;
    logic                take_frame;
    logic                sample_ok;
    logic [LEVEL_W-1:0]  target;
    logic [LEVEL_W-1:0]  level_decayed;
    logic [LEVEL_W-1:0]  level_next;

    // A new frame is only accepted while idle; enable gates both inputs.
    assign take_frame = (state == ST_IDLE) && frame_start && enable;
    assign sample_ok  = rx_valid && enable;

    // Running maximum of the current frame. On a commit the old maximum is
    // snapshotted and a byte arriving in that same cycle seeds the next frame.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            cand <= '0;
        end else if (take_frame) begin
            cand <= acc;
            acc  <= sample_ok ? rx_data : '0;
        end else if (sample_ok && (rx_data > acc)) begin
            acc <= rx_data;
        end
    end

    // Commit sequencer: once started, a commit always runs to completion,
    // regardless of enable or further frame_start pulses.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (take_frame) state <= ST_UPD_LEVEL;
                ST_UPD_LEVEL: state <= ST_UPD_PEAK;
                ST_UPD_PEAK:  state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Bar level: rise instantly to the frame maximum, fall by at most one
    // decay step per frame, clamped at zero.
    always_comb begin
        target        = LEVEL_W'(cand >> SHIFT);
        level_decayed = (level > DECAY) ? (level - DECAY) : '0;
        level_next    = level_decayed;
        if (target >= level) begin
            level_next = target;
        end else if (target > level_decayed) begin
            level_next = target;
        end
    end

    // Level register is written one cycle after the frame is accepted.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if (state == ST_UPD_LEVEL) begin
            level <= level_next;
        end
    end

    // Valid pulse lines up with the peak register update, one cycle after level.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            level_valid <= 1'b0;
        end else begin
            level_valid <= (state == ST_UPD_PEAK);
        end
    end

    vu_peak_hold #(
        .LEVEL_W     (LEVEL_W),
        .DECAY_STEP  (DECAY_STEP),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_peak_hold (
        .clk_board (clk_board),
        .reset     (reset),
        .update    (state == ST_UPD_PEAK),
        .level     (level),
        .peak      (peak)
    );

endmodule

// File: tb/tb_vu_level_ctrl.sv
// Testbench for vu_level_ctrl: directed frame sequences plus randomized
// traffic, with a frame-level reference model feeding a scoreboard that a
// separate monitor drains on every level_valid pulse.
module tb_vu_level_ctrl;

    localparam int SAMPLE_W    = 8;
    localparam int LEVEL_W     = 5;
    localparam int DECAY_STEP  = 1;
    localparam int HOLD_FRAMES = 3;
    localparam int LEVEL_DIV   = 1 << (SAMPLE_W - LEVEL_W);

    logic                clk_board   = 1'b0;
    logic                reset       = 1'b1;
    logic                enable      = 1'b0;
    logic [SAMPLE_W-1:0] rx_data     = '0;
    logic                rx_valid    = 1'b0;
    logic                frame_start = 1'b0;
    logic [LEVEL_W-1:0]  level;
    logic [LEVEL_W-1:0]  peak;
    logic                level_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lvl;
        int pk;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: frame maximum, displayed level/peak, hold frames
    // left, and how many more cycles the DUT is busy committing.
    int m_acc   = 0;
    int m_level = 0;
    int m_peak  = 0;
    int m_hold  = 0;
    int m_busy  = 0;

    vu_level_ctrl #(
        .SAMPLE_W    (SAMPLE_W),
        .LEVEL_W     (LEVEL_W),
        .DECAY_STEP  (DECAY_STEP),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk_board   (clk_board),
        .reset       (reset),
        .enable      (enable),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .level       (level),
        .peak        (peak),
        .level_valid (level_valid)
    );

    always #5 clk_board = ~clk_board;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_acc   = 0;
        m_level = 0;
        m_peak  = 0;
        m_hold  = 0;
        m_busy  = 0;
        exp_q.delete();
    endtask

    // One committed frame, computed from the display rules on plain integers.
    task automatic modelCommit(input int frame_max);
        int   t;
        int   fall;
        exp_t e;
        t    = frame_max / LEVEL_DIV;
        fall = m_level - DECAY_STEP;
        if (fall < 0) fall = 0;
        if (t >= m_level) m_level = t;
        else m_level = (t > fall) ? t : fall;
        if (m_level >= m_peak) begin
            m_peak = m_level;
            m_hold = HOLD_FRAMES;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else begin
            fall = m_peak - DECAY_STEP;
            if (fall < 0) fall = 0;
            m_peak = (m_level > fall) ? m_level : fall;
        end
        e.lvl = m_level;
        e.pk  = m_peak;
        exp_q.push_back(e);
    endtask

    // Predict what the DUT does with the inputs sampled at the next edge.
    task automatic modelStep(input logic rxv, input logic [7:0] rxd, input logic fs, input logic en);
        bit byte_ok;
        int snap;
        byte_ok = rxv && en;
        if (m_busy == 0 && fs && en) begin
            snap   = m_acc;
            m_acc  = byte_ok ? int'(rxd) : 0;
            m_busy = 2;
            modelCommit(snap);
        end else begin
            if (m_busy > 0) m_busy = m_busy - 1;
            if (byte_ok && int'(rxd) > m_acc) m_acc = int'(rxd);
        end
    endtask

    task automatic applyStimulus(input logic rxv, input logic [7:0] rxd, input logic fs, input logic en);
        @(posedge clk_board);
        #1;
        rx_valid    = rxv;
        rx_data     = rxd;
        frame_start = fs;
        enable      = en;
        modelStep(rxv, rxd, fs, en);
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b1);
    endtask

    // Commit a frame and check the level one cycle later and the peak/valid pulse after two.
    task automatic runFrame(input logic rxv, input logic [7:0] rxd,
                            input int exp_level, input int exp_peak, input string tag);
        applyStimulus(rxv, rxd, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk_board);
        checkOutput({tag, "_level_n1"}, int'(level), exp_level);
        checkOutput({tag, "_valid_n1"}, int'(level_valid), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk_board);
        checkOutput({tag, "_valid_n2"}, int'(level_valid), 1);
        checkOutput({tag, "_peak_n2"}, int'(peak), exp_peak);
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest predicted frame.
    always @(negedge clk_board) begin
        exp_t e;
        if (reset && level_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_level", int'(level), e.lvl);
                checkOutput("sb_peak", int'(peak), e.pk);
                checkOutput("sb_peak_ge_level", int'(peak >= level), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected self-termination");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       r_en;
        logic       r_rxv;
        logic       r_fs;
        logic [7:0] r_d;

        $display("[TB] vu_level_ctrl bench start");

        // Reset state
        #3 reset = 1'b0;
        #4;
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_peak", int'(peak), 0);
        checkOutput("rst_valid", int'(level_valid), 0);
        modelReset();
        @(posedge clk_board);
        #1 reset = 1'b1;

        // Empty first frame commits zero
        runFrame(1'b0, 8'h00, 0, 0, "t1");

        // Single byte 0xAA -> level 21
        sendByte(8'hAA);
        runFrame(1'b0, 8'h00, 21, 21, "t2");

        // Empty frames: level falls, peak held for three frames then falls
        runFrame(1'b0, 8'h00, 20, 21, "t4a");
        runFrame(1'b0, 8'h00, 19, 21, "t4b");
        runFrame(1'b0, 8'h00, 18, 21, "t4c");
        runFrame(1'b0, 8'h00, 17, 20, "t4d");

        // Maximum kept regardless of arrival order
        sendByte(8'h55);
        sendByte(8'hAA);
        runFrame(1'b0, 8'h00, 21, 21, "t3");

        // Byte coincident with frame_start lands in the next frame
        sendByte(8'hAA);
        runFrame(1'b1, 8'h55, 21, 21, "t5a");
        runFrame(1'b0, 8'h00, 20, 21, "t5b");

        // Reset during the peak-update cycle clears outputs immediately
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        #1 reset = 1'b0;
        #1;
        checkOutput("t6_level", int'(level), 0);
        checkOutput("t6_peak", int'(peak), 0);
        checkOutput("t6_valid", int'(level_valid), 0);
        modelReset();
        repeat (2) @(posedge clk_board);
        #1 reset = 1'b1;

        // Disabled: bytes and frame_start ignored, outputs unchanged
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk_board);
        checkOutput("t6_dis_level", int'(level), 0);
        checkOutput("t6_dis_peak", int'(peak), 0);
        runFrame(1'b0, 8'h00, 0, 0, "t6c");

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            r_en  = ($urandom_range(0, 7) != 0);
            r_rxv = ($urandom_range(0, 2) == 0);
            r_fs  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) r_d = 8'($urandom_range(192, 255));
            else r_d = 8'($urandom_range(0, 255));
            applyStimulus(r_rxv, r_d, r_fs, r_en);
        end

        // Let any in-flight commit finish, then every prediction must be consumed
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk_board);
        checkOutput("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
